alu_breg: RTL and testbench
===========================

Name: alu_breg

Overview:
- Arithmetic stage that sits directly downstream of the accumulator. It consumes the accumulator's dedicated ALU output.
- Holds the B operand register and computes ADD/SUB combinationally.
- Contains a multi-cycle 8x8 shift-add multiplier with START/BUSY/DONE handshake.
- Drives the selected result onto the shared 8-bit DBUS and latches carry/zero flags for the controller.

Parameters:
- WIDTH, 8, data path width (DBUS, ACC, B).
- MUL_CYCLES, 8, shift-add iterations; must equal WIDTH.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- nLb  input  1  load B from DBUS at posedge when 0.
- Eu  input  1  drive selected result onto DBUS when 1, else Z.
- nLf  input  1  latch CF/ZF at posedge when 0.
- OP  input  2  result select: 00 ADD, 01 SUB, 10 MUL (product low byte), 11 MULH (product high byte).
- START  input  1  one-cycle request to begin multiply.
- ACC  input  WIDTH  accumulator value (from accumulator ALU output).
- DBUS  inout  WIDTH  shared bus.
- BUSY  output  1  multiply in progress.
- DONE  output  1  one-cycle pulse: product register updated.
- CF  output  1  latched carry flag.
- ZF  output  1  latched zero flag.

Behaviour:
- Reset (async, nRST=0): B=0, product register=0, working regs=0, CF=0, ZF=0, BUSY=0, DONE=0, state=IDLE. DBUS is Z whenever Eu=0, including during reset.
- Result mux (combinational):
  - ADD = ACC+B mod 256, carry-out = bit 8.
  - SUB = ACC+~B+1 mod 256; CF = carry-out (1 means no borrow, ACC>=B).
  - MUL = PROD[7:0]; MULH = PROD[15:8]; CF-candidate = (PROD[15:8]!=0).
- ZF-candidate = (selected result==0).
- DBUS = result whenever Eu=1, zero latency, independent of BUSY.
- B load: nLb=0 at posedge and not BUSY -> B<=DBUS. Ignored while BUSY, so B is frozen during a multiply.
- Flags: nLf=0 at posedge -> CF/ZF <= candidates, computed from pre-edge B/PROD. With nLb and nLf both asserted on the same edge, flags use the old B.
- Multiplier FSM:
  - IDLE: START=1 -> latch MCAND=ACC, MPLIER=B, WORK=0, CNT=0; go RUN, BUSY=1.
  - RUN: each cycle, if MPLIER[0] then WORK[16:8]<=WORK[15:8]+MCAND (9-bit, keeps carry), then shift {carry,WORK,MPLIER} right by 1; CNT++. After cycle with CNT=MUL_CYCLES-1 -> go DONE.
  - DONE: PROD<=assembled 16-bit product, DONE=1 for exactly one cycle, BUSY=0; go IDLE.
  - Latency: START sampled at edge n -> BUSY high for edges n+1..n+8, DONE high during cycle after edge n+9. PROD is visible on MUL/MULH from that cycle onward.
- PROD changes only in DONE. Reading MUL/MULH while BUSY returns the previous completed product.
- START while BUSY or in DONE is ignored (no queueing).
- Reset mid-multiply aborts immediately: PROD=0, BUSY=0, no DONE pulse.
- Eu=1 together with nLb=0 is bus contention and illegal. The bench asserts on it; the RTL still loads the resolved DBUS value.
- OP changes mid-multiply do not affect the multiply, only the result mux.

Decomposition:
- Package sap_alu_pkg:
  - OP encodings: OP_ADD, OP_SUB, OP_MUL, OP_MULH.
  - FSM state encoding: IDLE, RUN, DONE.
  - MUL_CYCLES default.
  - Flag bit indices.
- Sub-module sap_shift_add_mul: FSM, counter, working registers, PROD, BUSY/DONE.
- alu_breg keeps B, the adder/subtractor, the result mux, the flags and the tristate driver.

Test Plan:
- Reset then nLb=0, DBUS=0x01; ACC=0x0F, OP=ADD, Eu=1, nLf=0 -> DBUS=0x10, CF=0, ZF=0.
- B=0xFF, ACC=0x01, OP=ADD, nLf=0 -> DBUS=0x00, CF=1, ZF=1. Then B=0x05, ACC=0x05, OP=SUB -> 0x00, CF=1, ZF=1. Then ACC=0x04 -> 0xFF, CF=0, ZF=0.
- B=0x34, ACC=0x12, START pulse -> BUSY high 8 cycles, DONE single pulse at START edge+9. Then OP=MUL gives 0xA8, OP=MULH gives 0x03; nLf with MULH -> CF=1, ZF=0.
- During multiply, drive nLb=0 with DBUS=0x77 and pulse START again -> B stays 0x34, only one DONE pulse, product 0x03A8. MUL read while BUSY returns the prior product (0x0000 after reset).
- Start 0xFF*0xFF, assert nRST=0 at RUN cycle 4 -> BUSY=0 immediately, no DONE, PROD=0, CF=ZF=0. After release, 0xFF*0xFF -> 0xFE01.
- Same-edge nLb=0 (DBUS=0x00) and nLf=0 with B=0x01, ACC=0xFF, OP=ADD -> flags from old B (CF=1, ZF=1), B becomes 0x00. Eu=0 -> DBUS observed Z.

Source files
------------

// File: rtl/sap_alu_pkg.sv
// ---------------------------------------------------------------------------
// sap_alu_pkg
// Shared definitions for the ALU / B-register stage:
//   - result select encodings driven on the OP input
//   - state encoding for the shift-add multiplier FSM
//   - default data width and multiplier iteration count
//   - bit positions of the latched flags
// No ports (package).
// ---------------------------------------------------------------------------
package sap_alu_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int MUL_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_MULH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_W  = 2;

endpackage

// File: rtl/sap_shift_add_mul.sv
// ---------------------------------------------------------------------------
// sap_shift_add_mul
// Multi-cycle unsigned WIDTH x WIDTH shift-add multiplier with a
// START / BUSY / DONE handshake. The product register only changes in the
// DONE state, so readers always see the last completed product.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request, honoured only in IDLE
//   mcand_in   multiplicand, captured on start
//   mplier_in  multiplier, captured on start
//   busy       high while iterations are running
//   done       one-cycle pulse: prod has just been updated
//   prod       last completed 2*WIDTH-bit product
// ---------------------------------------------------------------------------
module sap_shift_add_mul
  import sap_alu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_e         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] work_q,   work_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic               done_q,   done_d;
  logic [WIDTH:0]     partial_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      work_q   <= '0;
      prod_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      work_q   <= work_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
    end
  end

  // Each RUN cycle adds the multiplicand into the upper half of the working
  // register (9-bit sum keeps the carry), then shifts {carry, work, mplier}
  // right by one. After WIDTH iterations work holds the full product; the
  // bits falling into mplier are don't-care.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    work_d      = work_q;
    prod_d      = prod_q;
    done_d      = 1'b0;
    partial_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = mcand_in;
          mplier_d = mplier_in;
          work_d   = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d   = {partial_sum, work_q[WIDTH-1:1]};
        mplier_d = {work_q[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        prod_d  = work_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign prod = prod_q;

endmodule

// File: rtl/alu_breg.sv
// ---------------------------------------------------------------------------
// alu_breg
// Arithmetic stage downstream of the accumulator. Holds the B operand
// register, forms ADD/SUB combinationally, hosts the shift-add multiplier,
// drives the selected result onto the shared bus and latches carry/zero.
// Ports:
//   CLK    rising-edge clock
//   nRST   asynchronous active-low reset
//   nLb    load B from DBUS at posedge when 0 (ignored while BUSY)
//   Eu     drive the selected result onto DBUS when 1, else release it
//   nLf    latch CF/ZF at posedge when 0
//   OP     result select: ADD, SUB, MUL (low byte), MULH (high byte)
//   START  one-cycle multiply request
//   ACC    accumulator value
//   DBUS   shared tristate data bus
//   BUSY   multiply in progress
//   DONE   one-cycle pulse when the product register updates
//   CF/ZF  latched carry and zero flags
// ---------------------------------------------------------------------------
module alu_breg
  import sap_alu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             nLb,
  input  logic             Eu,
  input  logic             nLf,
  input  logic [1:0]       OP,
  input  logic             START,
  input  logic [WIDTH-1:0] ACC,
  inout  wire  [WIDTH-1:0] DBUS,
  output logic             BUSY,
  output logic             DONE,
  output logic             CF,
  output logic             ZF
);

  logic [WIDTH-1:0]   b_q,     b_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [2*WIDTH-1:0] prod;
  logic               mul_busy;
  logic               mul_done;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   result;
  logic               cf_cand;
  logic               zf_cand;

  sap_shift_add_mul #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (CLK),
    .rst_n     (nRST),
    .start     (START),
    .mcand_in  (ACC),
    .mplier_in (b_q),
    .busy      (mul_busy),
    .done      (mul_done),
    .prod      (prod)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      b_q     <= '0;
      flags_q <= '0;
    end else begin
      b_q     <= b_d;
      flags_q <= flags_d;
    end
  end

  // SUB is ACC + ~B + 1, so its carry-out reads as "no borrow" (ACC >= B).
  // For the multiply selections the carry candidate flags a non-zero high byte.
  always_comb begin
    add_full = {1'b0, ACC} + {1'b0, b_q};
    sub_full = {1'b0, ACC} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    result   = add_full[WIDTH-1:0];
    cf_cand  = add_full[WIDTH];

    case (op_e'(OP))
      OP_ADD: begin
        result  = add_full[WIDTH-1:0];
        cf_cand = add_full[WIDTH];
      end
      OP_SUB: begin
        result  = sub_full[WIDTH-1:0];
        cf_cand = sub_full[WIDTH];
      end
      OP_MUL: begin
        result  = prod[WIDTH-1:0];
        cf_cand = |prod[2*WIDTH-1:WIDTH];
      end
      OP_MULH: begin
        result  = prod[2*WIDTH-1:WIDTH];
        cf_cand = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        result  = add_full[WIDTH-1:0];
        cf_cand = add_full[WIDTH];
      end
    endcase

    zf_cand = (result == '0);
  end

  // B is frozen while the multiplier runs so the captured operand and the
  // visible B stay consistent. Flags always use pre-edge B/PROD, so a
  // same-edge B load does not leak into the flags.
  always_comb begin
    b_d     = b_q;
    flags_d = flags_q;
    if (!nLb && !mul_busy) begin
      b_d = DBUS;
    end
    if (!nLf) begin
      flags_d[FLAG_CF] = cf_cand;
      flags_d[FLAG_ZF] = zf_cand;
    end
  end

  assign DBUS = Eu ? result : 'z;
  assign BUSY = mul_busy;
  assign DONE = mul_done;
  assign CF   = flags_q[FLAG_CF];
  assign ZF   = flags_q[FLAG_ZF];

endmodule

// File: tb/tb_alu_breg.sv
// ---------------------------------------------------------------------------
// tb_alu_breg
// Directed and randomized checks of alu_breg against an arithmetic reference
// model (plain +, -, * on the operands plus a cycle count for multiply
// latency). The bench drives DBUS whenever Eu=0, so a released DUT bus reads
// back exactly the bench's value.
// ---------------------------------------------------------------------------
module tb_alu_breg;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       nLb;
  logic       Eu;
  logic       nLf;
  logic [1:0] OP;
  logic       START;
  logic [7:0] ACC;
  wire  [7:0] DBUS;
  logic       BUSY;
  logic       DONE;
  logic       CF;
  logic       ZF;
  logic [7:0] bus_drv;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [7:0]  b_m;
  logic [15:0] prod_m;
  logic        cf_m;
  logic        zf_m;
  logic        done_m;
  int          phase;
  logic [7:0]  opa;
  logic [7:0]  opb;

  assign DBUS = Eu ? 8'hzz : bus_drv;

  always #5 CLK = ~CLK;

  alu_breg dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .nLb   (nLb),
    .Eu    (Eu),
    .nLf   (nLf),
    .OP    (OP),
    .START (START),
    .ACC   (ACC),
    .DBUS  (DBUS),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .CF    (CF),
    .ZF    (ZF)
  );

  // Bus contention (Eu together with nLb) is illegal stimulus.
  always @(posedge CLK) begin
    if (nRST) begin
      assert (!(Eu && !nLb)) else begin
        checks++;
        fails++;
        $error("[TB] FAIL bus_contention: Eu=%0b nLb=%0b required no overlap", Eu, nLb);
      end
    end
  end

  // Returns {carry candidate, result} from plain arithmetic on the operands.
  function automatic logic [8:0] modelEval(input logic [1:0] op, input logic [7:0] acc);
    int unsigned a;
    int unsigned b;
    logic [7:0]  r;
    logic        c;
    a = acc;
    b = b_m;
    case (op)
      2'd0: begin
        r = 8'((a + b) % 256);
        c = (a + b) > 255;
      end
      2'd1: begin
        r = 8'((a + 256 - b) % 256);
        c = (a >= b);
      end
      2'd2: begin
        r = prod_m[7:0];
        c = (prod_m > 16'd255);
      end
      default: begin
        r = prod_m[15:8];
        c = (prod_m > 16'd255);
      end
    endcase
    return {c, r};
  endfunction

  task automatic resetModel();
    b_m    = 8'h00;
    prod_m = 16'h0000;
    cf_m   = 1'b0;
    zf_m   = 1'b0;
    done_m = 1'b0;
    phase  = 0;
    opa    = 8'h00;
    opb    = 8'h00;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [8:0] m;
    m = modelEval(OP, ACC);
    checkOutput({tag, "/dbus"}, {8'h00, DBUS}, {8'h00, (Eu ? m[7:0] : bus_drv)});
    checkOutput({tag, "/busy"}, {15'h0, BUSY}, {15'h0, (phase >= 1 && phase <= 8)});
    checkOutput({tag, "/done"}, {15'h0, DONE}, {15'h0, done_m});
    checkOutput({tag, "/cf"},   {15'h0, CF},   {15'h0, cf_m});
    checkOutput({tag, "/zf"},   {15'h0, ZF},   {15'h0, zf_m});
  endtask

  task automatic applyStimulus(input logic nlb, input logic eu, input logic nlf, input logic st,
                               input logic [1:0] op, input logic [7:0] acc, input logic [7:0] bus);
    nLb     = nlb;
    Eu      = eu;
    nLf     = nlf;
    START   = st;
    OP      = op;
    ACC     = acc;
    bus_drv = bus;
    #1;
  endtask

  // Advances the model with the pre-edge inputs, then takes the clock edge.
  // phase 0 = idle, 1..8 = iterations in progress, 9 = product commit cycle.
  task automatic clockEdge();
    logic [8:0] m;
    logic [7:0] b_new;
    m     = modelEval(OP, ACC);
    b_new = b_m;
    if (nRST) begin
      if (!nLb && !(phase >= 1 && phase <= 8)) b_new = Eu ? m[7:0] : bus_drv;
      if (!nLf) begin
        cf_m = m[8];
        zf_m = (m[7:0] == 8'h00);
      end
      done_m = 1'b0;
      if (phase == 0) begin
        if (START) begin
          phase = 1;
          opa   = ACC;
          opb   = b_m;
        end
      end else if (phase <= 8) begin
        phase++;
      end else begin
        prod_m = 16'(opa) * 16'(opb);
        done_m = 1'b1;
        phase  = 0;
      end
      b_m = b_new;
    end
    @(posedge CLK);
    #2;
  endtask

  initial begin
    nRST = 1'b0;
    resetModel();
    applyStimulus(1, 0, 1, 0, 2'd0, 8'h00, 8'h5A);
    #2;
    checkAll("reset_released_bus");
    applyStimulus(1, 1, 1, 0, 2'd0, 8'h0F, 8'h00);
    checkAll("reset_add");
    applyStimulus(1, 1, 1, 0, 2'd2, 8'h0F, 8'h00);
    checkAll("reset_mul");
    @(posedge CLK);
    #2;
    nRST = 1'b1;

    // Basic ADD with flags
    applyStimulus(0, 0, 1, 0, 2'd0, 8'h0F, 8'h01);
    clockEdge();
    applyStimulus(1, 1, 0, 0, 2'd0, 8'h0F, 8'h00);
    checkAll("add_0f_01");
    clockEdge();
    checkAll("add_flags");

    // ADD wrap, SUB equal, SUB borrow
    applyStimulus(0, 0, 1, 0, 2'd0, 8'h01, 8'hFF);
    clockEdge();
    applyStimulus(1, 1, 0, 0, 2'd0, 8'h01, 8'h00);
    clockEdge();
    checkAll("add_wrap");
    applyStimulus(0, 0, 1, 0, 2'd1, 8'h05, 8'h05);
    clockEdge();
    applyStimulus(1, 1, 0, 0, 2'd1, 8'h05, 8'h00);
    clockEdge();
    checkAll("sub_equal");
    applyStimulus(1, 1, 0, 0, 2'd1, 8'h04, 8'h00);
    clockEdge();
    checkAll("sub_borrow");

    // Multiply 0x12 * 0x34 with ignored load and restart mid-run
    applyStimulus(0, 0, 1, 0, 2'd0, 8'h12, 8'h34);
    clockEdge();
    applyStimulus(1, 1, 1, 1, 2'd2, 8'h12, 8'h00);
    checkAll("mul_pre");
    clockEdge();
    applyStimulus(1, 1, 1, 0, 2'd2, 8'h12, 8'h00);
    checkAll("mul_read_prior");
    clockEdge();
    applyStimulus(0, 0, 1, 1, 2'd2, 8'h12, 8'h77);
    checkAll("mul_ignore_load");
    clockEdge();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 1, 0, 2'd3, 8'h55, 8'h00);
      checkAll("mul_run");
      clockEdge();
    end
    applyStimulus(1, 1, 1, 0, 2'd2, 8'h00, 8'h00);
    checkAll("mul_lo");
    checkOutput("mul_lo_value", {8'h00, DBUS}, 16'h00A8);
    applyStimulus(1, 1, 0, 0, 2'd3, 8'h00, 8'h00);
    checkAll("mul_hi");
    checkOutput("mul_hi_value", {8'h00, DBUS}, 16'h0003);
    clockEdge();
    applyStimulus(1, 1, 1, 0, 2'd0, 8'h00, 8'h00);
    checkAll("mul_b_kept");
    checkOutput("mul_b_value", {8'h00, DBUS}, 16'h0034);

    // Reset in the middle of 0xFF * 0xFF
    applyStimulus(0, 0, 1, 0, 2'd0, 8'hFF, 8'hFF);
    clockEdge();
    applyStimulus(1, 0, 1, 1, 2'd0, 8'hFF, 8'h3C);
    clockEdge();
    applyStimulus(1, 0, 1, 0, 2'd0, 8'hFF, 8'h3C);
    for (int i = 0; i < 4; i++) clockEdge();
    checkAll("pre_abort");
    nRST = 1'b0;
    #1;
    resetModel();
    checkAll("abort");
    applyStimulus(1, 1, 1, 0, 2'd3, 8'hFF, 8'h00);
    checkAll("abort_prod");
    nRST = 1'b1;
    applyStimulus(0, 0, 1, 0, 2'd0, 8'hFF, 8'hFF);
    clockEdge();
    applyStimulus(1, 0, 1, 1, 2'd0, 8'hFF, 8'h3C);
    clockEdge();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 1, 0, 2'd0, 8'hFF, 8'h3C);
      checkAll("ff_run");
      clockEdge();
    end
    applyStimulus(1, 1, 1, 0, 2'd3, 8'h00, 8'h00);
    checkOutput("ff_hi_value", {8'h00, DBUS}, 16'h00FE);
    applyStimulus(1, 1, 1, 0, 2'd2, 8'h00, 8'h00);
    checkOutput("ff_lo_value", {8'h00, DBUS}, 16'h0001);

    // Same-edge B load and flag latch: flags see the old B
    applyStimulus(0, 0, 1, 0, 2'd0, 8'hFF, 8'h01);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 2'd0, 8'hFF, 8'h00);
    clockEdge();
    checkAll("same_edge_flags");
    checkOutput("same_edge_cf", {15'h0, CF}, 16'h0001);
    checkOutput("same_edge_zf", {15'h0, ZF}, 16'h0001);
    applyStimulus(1, 1, 1, 0, 2'd0, 8'h05, 8'h00);
    checkOutput("same_edge_b", {8'h00, DBUS}, 16'h0005);
    applyStimulus(1, 0, 1, 0, 2'd0, 8'h05, 8'hA5);
    checkAll("released_bus");

    // Random ADD/SUB with flag latching
    for (int i = 0; i < 24; i++) begin
      logic [7:0] rb;
      logic [7:0] ra;
      logic [1:0] rop;
      rb  = 8'($urandom);
      ra  = 8'($urandom);
      rop = 2'($urandom_range(0, 1));
      applyStimulus(0, 0, 1, 0, rop, ra, rb);
      clockEdge();
      applyStimulus(1, 1, 0, 0, rop, ra, 8'h00);
      checkAll("rand_alu");
      clockEdge();
      checkAll("rand_alu_flags");
    end

    // Random multiplies with OP/ACC churn during the run
    for (int i = 0; i < 4; i++) begin
      logic [7:0] rb;
      logic [7:0] ra;
      rb = 8'($urandom);
      ra = 8'($urandom);
      applyStimulus(0, 0, 1, 0, 2'd0, ra, rb);
      clockEdge();
      applyStimulus(1, 1, 1, 1, 2'd2, ra, 8'h00);
      clockEdge();
      for (int k = 0; k < 10; k++) begin
        applyStimulus(1, 1, 1, 0, 2'($urandom), 8'($urandom), 8'h00);
        checkAll("rand_mul_run");
        clockEdge();
      end
      applyStimulus(1, 1, 0, 0, 2'd2, 8'h00, 8'h00);
      checkOutput("rand_mul_lo", {8'h00, DBUS}, 16'(16'(ra) * 16'(rb)) & 16'h00FF);
      applyStimulus(1, 1, 0, 0, 2'd3, 8'h00, 8'h00);
      checkOutput("rand_mul_hi", {8'h00, DBUS}, 16'(16'(ra) * 16'(rb)) >> 8);
      clockEdge();
      checkAll("rand_mul_flags");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
